// File: rtl/data_memory_backend_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_backend_pkg
//   Shared definitions for the line-granular data memory backend: line and
//   address geometry, the counter width and the controller state encoding.
// ---------------------------------------------------------------------------
package data_memory_backend_pkg;

    localparam int LINE_BITS   = 256;  // one cache line
    localparam int ADDR_BITS   = 32;   // byte address width
    localparam int OFFSET_BITS = 5;    // byte offset inside a line, ignored
    localparam int CNT_BITS    = 8;    // latency counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a request
        BUSY = 2'd1,   // request latched, counting latency
        ACK  = 2'd2,   // completion pulse cycle
        GAP  = 2'd3    // one dead cycle before the next request can be taken
    } state_e;

endpackage : data_memory_backend_pkg

// File: rtl/data_memory_backend_line_array.sv
// ---------------------------------------------------------------------------
// dmem_line_array
//   Single-port line storage. Writes are synchronous; the read port is a
//   combinational view of the addressed line, registered by the caller.
//
//   clk_i    in   clock
//   we_i     in   write enable, commits line_i to mem[index_i] at the edge
//   index_i  in   line index (shared by read and write)
//   line_i   in   write line data
//   line_o   out  current contents of mem[index_i]
// ---------------------------------------------------------------------------
module dmem_line_array
    import data_memory_backend_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] index_i,
    input  logic [LINE_BITS-1:0]  line_i,
    output logic [LINE_BITS-1:0]  line_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [LINE_BITS-1:0] mem [DEPTH];

    // NOTE: storage has no reset; contents survive rst_i and are preloaded
    // externally, and a reset term would stop this mapping onto RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[index_i] <= line_i;
        end
    end

    assign line_o = mem[index_i];

endmodule : dmem_line_array

// File: rtl/data_memory_backend.sv
// ---------------------------------------------------------------------------
// data_memory_backend
//   Fixed-latency line memory behind the cache controller. A request sampled
//   in IDLE is latched, counted for MEM_LATENCY cycles, then completed with a
//   one-cycle ack: writes commit to the array, reads load data_o. ACK and GAP
//   each last one cycle and ignore enable_i, so a held enable is re-sampled
//   two cycles after ack. Dropping enable_i while BUSY aborts the request.
//
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-low reset
//   enable_i  in   request valid
//   write_i   in   1 = line write, 0 = line read
//   addr_i    in   byte address; [DEPTH_LOG2+4:5] selects the line
//   data_i    in   write line data
//   ack_o     out  one-cycle completion pulse
//   data_o    out  registered read data, held until the next read completes
// ---------------------------------------------------------------------------
module data_memory_backend
    import data_memory_backend_pkg::*;
#(
    parameter int MEM_LATENCY = 10,  // legal 2..255
    parameter int DEPTH_LOG2  = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    // The counter starts at 1 on the sampling edge, so reaching
    // MEM_LATENCY-1 in BUSY places the ack exactly MEM_LATENCY cycles later.
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MEM_LATENCY - 1);

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;

    logic                  req_write_q;
    logic [DEPTH_LOG2-1:0] req_index_q;
    logic [LINE_BITS-1:0]  req_data_q;

    logic                  sample_req;
    logic                  complete;
    logic [DEPTH_LOG2-1:0] addr_index;
    logic [LINE_BITS-1:0]  array_line;

    // Offset bits and bits above the index do not select anything; upper
    // bits simply alias onto the same line.
    assign addr_index = addr_i[DEPTH_LOG2+OFFSET_BITS-1:OFFSET_BITS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[ADDR_BITS-1:DEPTH_LOG2+OFFSET_BITS],
                                addr_i[OFFSET_BITS-1:0]};

    // NOTE: every signal driven here is given a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sample_req = 1'b0;
        complete   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_BITS'(1);
                    sample_req = 1'b1;
                end
            end
            BUSY: begin
                if (!enable_i) begin
                    // Abort: nothing commits and no ack is produced.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d  = ACK;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            ACK:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ack_o       <= 1'b0;
            data_o      <= '0;
            req_write_q <= 1'b0;
            req_index_q <= '0;
            req_data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= complete;

            if (sample_req) begin
                req_write_q <= write_i;
                req_index_q <= addr_index;
                req_data_q  <= data_i;
            end

            // The array read port already shows the latched line, so the
            // read result is captured on the same edge that enters ACK.
            if (complete && !req_write_q) begin
                data_o <= array_line;
            end
        end
    end

    dmem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (complete && req_write_q),
        .index_i (req_index_q),
        .line_i  (req_data_q),
        .line_o  (array_line)
    );

endmodule : data_memory_backend

// File: tb/tb_data_memory_backend.sv
// ---------------------------------------------------------------------------
// tb_data_memory_backend
//   Directed bench for data_memory_backend (MEM_LATENCY=10, 512 lines).
//   A transaction-level model tracks the request in flight by its start
//   cycle and predicts ack_o/data_o; a compare process checks both on every
//   falling edge. Directed tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_data_memory_backend;

    localparam int L     = 10;
    localparam int DL2   = 9;
    localparam int DEPTH = 512;

    logic         clk_i    = 1'b0;
    logic         rst_i    = 1'b0;
    logic         enable_i = 1'b0;
    logic         write_i  = 1'b0;
    logic [31:0]  addr_i   = '0;
    logic [255:0] data_i   = '0;
    logic         ack_o;
    logic [255:0] data_o;

    data_memory_backend #(
        .MEM_LATENCY (L),
        .DEPTH_LOG2  (DL2)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [255:0] model_mem [DEPTH];
    bit           m_ack       = 1'b0;
    logic [255:0] m_data      = '0;
    bit           m_pending   = 1'b0;
    int           m_start     = 0;
    int           m_next_free = 0;
    bit           m_wr        = 1'b0;
    int           m_idx       = 0;
    logic [255:0] m_wdata     = '0;

    function automatic int line_of(input logic [31:0] a);
        return int'(a[DL2+4:5]);
    endfunction

    // Called on each rising edge with the inputs of cycle 'cyc'; the state
    // it leaves describes the outputs of cycle cyc+1.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_ack       = 1'b0;
            m_data      = '0;
            m_pending   = 1'b0;
            m_next_free = 0;
        end else begin
            m_ack = 1'b0;
            if (m_pending) begin
                if (!enable_i) begin
                    m_pending = 1'b0;
                end else if (cyc == m_start + L - 1) begin
                    m_ack       = 1'b1;
                    m_pending   = 1'b0;
                    m_next_free = m_start + L + 2;
                    if (m_wr) model_mem[m_idx] = m_wdata;
                    else      m_data = model_mem[m_idx];
                end
            end else if (enable_i && cyc >= m_next_free) begin
                m_pending = 1'b1;
                m_start   = cyc;
                m_wr      = write_i;
                m_idx     = line_of(addr_i);
                m_wdata   = data_i;
            end
        end
    end

    always @(negedge clk_i) begin
        check("ack_o vs model", {255'b0, ack_o}, {255'b0, m_ack});
        check("data_o vs model", data_o, m_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] preload_of(input int i);
        logic [31:0] w;
        w = 32'hF000_0000 | 32'(i);
        return {8{w}};
    endfunction

    // Starts in a fresh IDLE cycle, holds enable through BUSY while
    // scrambling the other inputs, drops enable in the ack cycle and ends
    // in the GAP cycle.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                          input string tag);
        tick();
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = data;
        tick();
        write_i = ~wr;
        addr_i  = $urandom;
        data_i  = rnd256();
        repeat (L - 2) tick();
        mid();
        check({tag, " ack low at C+L-1"}, {255'b0, ack_o}, 256'd0);
        tick();
        mid();
        check({tag, " ack high at C+L"}, {255'b0, ack_o}, 256'd1);
        enable_i = 1'b0;
        tick();
        mid();
        check({tag, " ack low at C+L+1"}, {255'b0, ack_o}, 256'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, limit 50000 expected less");
        $fatal(1);
    end

    localparam logic [255:0] A5_LINE = {32{8'hA5}};
    localparam logic [255:0] WB_LINE = {4{64'hB00C_0000_5EED_1111}};
    localparam logic [255:0] ALIAS_LINE = {8{32'hCAFE_F00D}};
    localparam logic [255:0] TOP_LINE = {16{16'h7E57}};

    initial begin
        logic [255:0] lv;
        for (int i = 0; i < DEPTH; i++) begin
            lv = preload_of(i);
            dut.u_array.mem[i] = lv;
            model_mem[i] = lv;
        end
        dut.u_array.mem[3] = A5_LINE;
        model_mem[3] = A5_LINE;

        // Reset state
        repeat (3) tick();
        mid();
        check("reset ack_o", {255'b0, ack_o}, 256'd0);
        check("reset data_o", data_o, 256'd0);
        tick();
        rst_i = 1'b1;
        repeat (2) tick();

        // Read of preloaded line 3
        do_req(1'b0, 32'h0000_0060, '0, "read 0x60");
        check("read 0x60 data", data_o, A5_LINE);

        // Write then read; a write leaves data_o alone
        do_req(1'b1, 32'h0000_0080, 256'h1234, "write 0x80");
        check("write keeps data_o", data_o, A5_LINE);
        do_req(1'b0, 32'h0000_0080, '0, "read 0x80");
        check("read 0x80 data", data_o, 256'h1234);

        // Writeback then refill with enable held high
        begin
            int c0;
            tick();
            c0 = cyc;
            enable_i = 1'b1;
            write_i  = 1'b1;
            addr_i   = 32'h0000_0400;
            data_i   = WB_LINE;
            tick();
            data_i = rnd256();
            repeat (L - 1) tick();
            mid();
            check("writeback ack", {255'b0, ack_o}, 256'd1);
            tick();
            write_i = 1'b0;
            addr_i  = 32'h0000_0400;
            tick();
            repeat (L - 1) tick();
            mid();
            check("refill ack low at ack+11", {255'b0, ack_o}, 256'd0);
            tick();
            mid();
            check("refill ack at ack+12", {255'b0, ack_o}, 256'd1);
            check("refill cycle offset", 256'(cyc - c0), 256'(2 * L + 2));
            check("refill data", data_o, WB_LINE);
            enable_i = 1'b0;
            tick();
        end

        // Abort of a write to 0x40 in its fourth cycle
        begin
            tick();
            enable_i = 1'b1;
            write_i  = 1'b1;
            addr_i   = 32'h0000_0040;
            data_i   = 256'hDEAD;
            repeat (4) tick();
            enable_i = 1'b0;
            repeat (6) tick();
            mid();
            check("abort no ack at C+L", {255'b0, ack_o}, 256'd0);
            check("abort data_o held", data_o, WB_LINE);
        end
        do_req(1'b0, 32'h0000_0040, '0, "read 0x40");
        check("abort line unchanged", data_o, {8{32'hF000_0002}});

        // Reset in the sixth cycle of a write to line 5
        begin
            tick();
            enable_i = 1'b1;
            write_i  = 1'b1;
            addr_i   = 32'h0000_00A0;
            data_i   = '1;
            repeat (6) tick();
            rst_i = 1'b0;
            #1;
            check("reset immediate ack_o", {255'b0, ack_o}, 256'd0);
            check("reset immediate data_o", data_o, 256'd0);
            repeat (2) tick();
            enable_i = 1'b0;
            rst_i    = 1'b1;
            tick();
        end
        do_req(1'b0, 32'h0000_00A0, '0, "read 0xA0");
        check("reset write not committed", data_o, {8{32'hF000_0005}});

        // Aliased upper address bits
        do_req(1'b1, 32'h0000_4020, ALIAS_LINE, "write 0x4020");
        do_req(1'b0, 32'h0000_0020, '0, "read 0x20");
        check("alias read data", data_o, ALIAS_LINE);

        // Highest line, reached through an all-ones upper address
        do_req(1'b1, 32'h0000_3FE0, TOP_LINE, "write 0x3FE0");
        do_req(1'b0, 32'hFFFF_FFE0, '0, "read 0xFFFFFFE0");
        check("top line alias data", data_o, TOP_LINE);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_data_memory_backend
